mc_control_fsm: RTL



---
 rtl/mc_control_fsm_pkg.sv | 58 +++++
 rtl/mc_alu_decoder.sv | 47 ++++
 rtl/mc_control_fsm.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, ALU ops, states, datapath selects.
package mc_control_fsm_pkg;

  localparam int ALUC_W  = 4;
  localparam int STATE_W = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALUC_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALUC_W-1:0] ALU_SRA  = 4'b0100;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_SLTU = 4'b1000;
  localparam logic [ALUC_W-1:0] ALU_XOR  = 4'b1001;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2,
    S_LUI, S_AUIPC, S_ILLEGAL
  } state_t;

  // Which funct3 interpretation the ALU decoder applies in the current state.
  typedef enum logic [1:0] {
    ALUCLS_ADD, ALUCLS_R, ALUCLS_I, ALUCLS_BR
  } alu_cls_t;

  localparam logic [1:0] RES_ALUREG  = 2'd0;
  localparam logic [1:0] RES_MEMDATA = 2'd1;
  localparam logic [1:0] RES_ALUOUT  = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU op decode from funct3/funct7b5 per state class, plus branch-taken resolution from zero.
// Latency: purely combinational.
// Backpressure: none; follows its inputs every cycle.
module mc_alu_decoder
  import mc_control_fsm_pkg::*;
(
  input  alu_cls_t          cls,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              zero,
  output logic [ALUC_W-1:0] aluc,
  output logic              taken
);

  always_comb begin
    aluc  = ALU_ADD;
    taken = 1'b0;
    case (cls)
      ALUCLS_R, ALUCLS_I: begin
        case (funct3)
          3'b000:  aluc = (cls == ALUCLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  aluc = ALU_SLL;
          3'b010:  aluc = ALU_SLT;
          3'b011:  aluc = ALU_SLTU;
          3'b100:  aluc = ALU_XOR;
          3'b101:  aluc = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  aluc = ALU_OR;
          default: aluc = ALU_AND;
        endcase
      end
      ALUCLS_BR: begin
        // Less-than compares produce 1 when true, so zero==0 means the relation held.
        case (funct3)
          3'b000:  begin aluc = ALU_SUB;  taken = zero;  end
          3'b001:  begin aluc = ALU_SUB;  taken = ~zero; end
          3'b100:  begin aluc = ALU_SLT;  taken = ~zero; end
          3'b101:  begin aluc = ALU_SLT;  taken = zero;  end
          3'b110:  begin aluc = ALU_SLTU; taken = ~zero; end
          3'b111:  begin aluc = ALU_SLTU; taken = zero;  end
          default: begin aluc = ALU_SUB;  taken = 1'b0;  end
        endcase
      end
      default: aluc = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main controller; MC_ILLEGAL_TRAP_EN makes the ILLEGAL state a terminal trap.
// Latency: one state per clock; FETCH/MEMREAD/MEMWRITE stall until mem_ready.
// Backpressure: memory stalls hold state; all other states advance unconditionally.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              adr_src,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_write,
  output logic [1:0]        result_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [2:0]        imm_src,
  output logic [ALUC_W-1:0] aluc,
  output logic              illegal
);

  state_t   state, state_nxt;
  alu_cls_t cls;
  logic     taken;

  mc_alu_decoder u_alu_dec (
    .cls      (cls),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .zero     (zero),
    .aluc     (aluc),
    .taken    (taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_FOUR;
    imm_src    = IMM_I;
    cls        = ALUCLS_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        // JAL target is formed here so it sits in the ALU result reg for the JAL state.
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXECR;
          OP_I:              state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
          default:           state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        cls       = ALUCLS_R;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        cls       = ALUCLS_I;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUREG;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUREG;
        cls        = ALUCLS_BR;
        pc_write   = taken;
        state_nxt  = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_nxt = S_JALR2;
      end
      S_JALR2: begin
        alu_src_a  = SRCA_OLDPC;
        result_src = RES_ALUREG;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_nxt = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_nxt = S_ALUWB;
      end
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        illegal   = 1'b1;
        state_nxt = S_ILLEGAL;
`else
        state_nxt = S_FETCH;
`endif
      end
    endcase
  end

endmodule
